// File: rtl/sd_tx_fifo.sv
// Transmit FIFO for the SD data path: 32-bit words in, 4-bit nibbles out.
// A one-word holding register feeds the serializer so nibbles stream gap-free across words.
module sd_tx_fifo #(
  parameter int DEPTH      = 8,
  parameter int ADR_W      = 4,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [31:0]      d,
  input  logic             wr,
  output logic [3:0]       q,
  input  logic             rd,
  output logic             nib_valid,
  output logic             full,
  output logic             empty,
  output logic [ADR_W-1:0] level,
  output logic             underrun
);

  localparam int LW = ADR_W - 1;
  localparam logic [ADR_W-1:0] PTR_ONE = {{(ADR_W-1){1'b0}}, 1'b1};

  logic [31:0]      mem [DEPTH];
  logic [ADR_W-1:0] wptr_q, wptr_d;
  logic [ADR_W-1:0] rptr_q, rptr_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [31:0]      hold_q, hold_d;
  logic             hv_q, hv_d;
  logic             underrun_q, underrun_d;

  logic             se;
  logic             wr_en;
  logic             pop;
  logic [2:0]       sel;

  // All status terms use pre-edge state, so a same-cycle write never bypasses to hold.
  assign se    = (wptr_q == rptr_q);
  assign full  = (wptr_q[LW-1:0] == rptr_q[LW-1:0]) && (wptr_q[LW] != rptr_q[LW]);
  assign wr_en = wr && !full;
  assign pop   = !se && (!hv_q || (rd && (cnt_q == 3'd7)));

  assign level     = wptr_q - rptr_q;
  assign empty     = se && !hv_q;
  assign nib_valid = hv_q;
  assign underrun  = underrun_q;

  assign sel = BIG_ENDIAN ? ~cnt_q : cnt_q;
  assign q   = hold_q[{sel, 2'b00} +: 4];

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    hv_d       = hv_q;
    underrun_d = underrun_q;
    if (clr) begin
      wptr_d     = '0;
      rptr_d     = '0;
      cnt_d      = '0;
      hold_d     = '0;
      hv_d       = 1'b0;
      underrun_d = 1'b0;
    end else begin
      if (wr_en) wptr_d = wptr_q + PTR_ONE;
      if (rd && !hv_q) underrun_d = 1'b1;
      if (pop) begin
        hold_d = mem[rptr_q[LW-1:0]];
        hv_d   = 1'b1;
        cnt_d  = 3'd0;
        rptr_d = rptr_q + PTR_ONE;
      end else if (rd && hv_q) begin
        if (cnt_q != 3'd7) begin
          cnt_d = cnt_q + 3'd1;
        end else begin
          hv_d  = 1'b0;
          cnt_d = 3'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem[wptr_q[LW-1:0]] <= d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      hv_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      hv_q       <= hv_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_sd_tx_fifo.sv
// Bench for sd_tx_fifo: both nibble orders driven in parallel and checked against a queue model.
module tb_sd_tx_fifo;

  localparam int DEPTH = 8;
  localparam int ADR_W = 4;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic [31:0]      d;
  logic             wr;
  logic             rd;
  logic [3:0]       q_be, q_le;
  logic             nv_be, nv_le, full_be, full_le, empty_be, empty_le, un_be, un_le;
  logic [ADR_W-1:0] lvl_be, lvl_le;

  sd_tx_fifo #(.DEPTH(DEPTH), .ADR_W(ADR_W), .BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .rst_n(rst_n), .clr(clr), .d(d), .wr(wr), .q(q_be), .rd(rd),
    .nib_valid(nv_be), .full(full_be), .empty(empty_be), .level(lvl_be), .underrun(un_be)
  );

  sd_tx_fifo #(.DEPTH(DEPTH), .ADR_W(ADR_W), .BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .rst_n(rst_n), .clr(clr), .d(d), .wr(wr), .q(q_le), .rd(rd),
    .nib_valid(nv_le), .full(full_le), .empty(empty_le), .level(lvl_le), .underrun(un_le)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: stored words, holding word, nibble index
  logic [31:0] exp_q[$];
  logic [31:0] m_hold;
  logic        m_hv;
  int          m_nib;
  logic        m_under;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [3:0] nibble(input logic [31:0] w, input int n, input bit be);
    logic [31:0] s;
    s = w >> (4 * (be ? 7 - n : n));
    return s[3:0];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_hold  = '0;
    m_hv    = 1'b0;
    m_nib   = 0;
    m_under = 1'b0;
  endtask

  task automatic model_edge(input logic w, input logic [31:0] dv, input logic r, input logic c);
    int pre;
    bit take;
    if (c) begin
      model_reset();
      return;
    end
    pre  = exp_q.size();
    take = 1'b0;
    if (r && !m_hv) m_under = 1'b1;
    if (pre > 0 && (!m_hv || (r && m_nib == 7))) take = 1'b1;
    else if (r && m_hv) begin
      if (m_nib < 7) m_nib++;
      else begin m_hv = 1'b0; m_nib = 0; end
    end
    if (w && pre < DEPTH) exp_q.push_back(dv);
    if (take) begin
      m_hold = exp_q.pop_front();
      m_hv   = 1'b1;
      m_nib  = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_nv_be"},    {31'd0, nv_be},    {31'd0, m_hv});
    check({tag, "_nv_le"},    {31'd0, nv_le},    {31'd0, m_hv});
    check({tag, "_q_be"},     {28'd0, q_be},     {28'd0, nibble(m_hold, m_nib, 1'b1)});
    check({tag, "_q_le"},     {28'd0, q_le},     {28'd0, nibble(m_hold, m_nib, 1'b0)});
    check({tag, "_full"},     {30'd0, full_be, full_le},
          {30'd0, {2{exp_q.size() == DEPTH}}});
    check({tag, "_empty"},    {30'd0, empty_be, empty_le},
          {30'd0, {2{exp_q.size() == 0 && !m_hv}}});
    check({tag, "_level"},    {24'd0, lvl_be, lvl_le}, {24'd0, 4'(exp_q.size()), 4'(exp_q.size())});
    check({tag, "_underrun"}, {30'd0, un_be, un_le},   {30'd0, m_under, m_under});
  endtask

  // driver: called at a falling edge, applies inputs for one rising edge, checks at the next falling edge
  task automatic step(input string tag, input logic w, input logic [31:0] dv,
                      input logic r, input logic c);
    wr = w; d = dv; rd = r; clr = c;
    @(posedge clk);
    model_edge(w, dv, r, c);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
    check_all(tag);
  endtask

  task automatic read_nibbles(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  logic [3:0] seq_be[$];
  logic [3:0] seq_le[$];

  initial begin
    rst_n = 1'b0; clr = 1'b0; d = '0; wr = 1'b0; rd = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    check("reset_q0", {28'd0, q_be}, 32'd0);
    rst_n = 1'b1;

    // single word, both nibble orders
    step("t1_wr", 1'b1, 32'h12345678, 1'b0, 1'b0);
    check("t1_nv_after_write", {31'd0, nv_be}, 32'd0);
    step("t1_pop", 1'b0, 32'h0, 1'b0, 1'b0);
    check("t1_nv_after_pop", {31'd0, nv_be}, 32'd1);
    seq_be.delete(); seq_le.delete();
    for (int i = 0; i < 8; i++) begin
      seq_be.push_back(q_be); seq_le.push_back(q_le);
      step("t1_rd", 1'b0, 32'h0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      check("t1_seq_be", {28'd0, seq_be[i]}, 32'(i + 1));
      check("t1_seq_le", {28'd0, seq_le[i]}, 32'(8 - i));
    end
    check("t1_empty_end", {31'd0, empty_be}, 32'd1);

    // back-to-back words, no gap
    step("t3_wr", 1'b1, 32'hAAAAAAAA, 1'b0, 1'b0);
    step("t3_wr", 1'b1, 32'h55555555, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check("t3_gapless_nv", {31'd0, nv_be}, 32'd1);
      check("t3_nib", {28'd0, q_be}, (i < 8) ? 32'hA : 32'h5);
      step("t3_rd", 1'b0, 32'h0, 1'b1, 1'b0);
    end

    // overfill: DEPTH + 2 words
    for (int i = 0; i < DEPTH + 2; i++) step("t4_wr", 1'b1, 32'(i), 1'b0, 1'b0);
    check("t4_full", {31'd0, full_be}, 32'd1);
    check("t4_level", {28'd0, lvl_be}, 32'd8);
    for (int w = 0; w < DEPTH + 1; w++) begin
      check("t4_word_hold", {31'd0, nv_be}, 32'd1);
      for (int n = 0; n < 8; n++) begin
        check("t4_nib", {28'd0, q_be}, (n == 7) ? 32'(w) : 32'd0);
        step("t4_rd", 1'b0, 32'h0, 1'b1, 1'b0);
      end
    end
    check("t4_drained", {31'd0, empty_be}, 32'd1);

    // underrun sticky until clr
    step("t5_rd", 1'b0, 32'h0, 1'b1, 1'b0);
    step("t5_rd", 1'b0, 32'h0, 1'b1, 1'b0);
    check("t5_underrun", {31'd0, un_be}, 32'd1);
    step("t5_wr", 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    step("t5_pop", 1'b0, 32'h0, 1'b0, 1'b0);
    read_nibbles("t5_rd", 8);
    check("t5_underrun_sticky", {31'd0, un_be}, 32'd1);
    step("t5_clr", 1'b0, 32'h0, 1'b0, 1'b1);
    check("t5_underrun_clr", {31'd0, un_be}, 32'd0);

    // clr wins over wr and rd mid-word
    for (int i = 0; i < 3; i++) step("t6_wr", 1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0);
    read_nibbles("t6_rd", 3);
    step("t6_clr", 1'b1, 32'h77777777, 1'b1, 1'b1);
    check("t6_empty", {31'd0, empty_be}, 32'd1);
    check("t6_level", {28'd0, lvl_be}, 32'd0);
    step("t6_wr", 1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
    step("t6_pop", 1'b0, 32'h0, 1'b0, 1'b0);
    read_nibbles("t6_rd", 8);

    // asynchronous reset between edges, mid-word
    for (int i = 0; i < 3; i++) step("t7_wr", 1'b1, 32'h2000 + 32'(i), 1'b0, 1'b0);
    read_nibbles("t7_rd", 2);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("t7_async");
    check("t7_q_zero", {28'd0, q_be}, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_all("t7_released");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic w, r, c;
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 60);
      c = ($urandom_range(0, 99) < 2);
      step("rand", w, $urandom(), r, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
